hilo_muldiv_ctrl: RTL and testbench
===================================

// Module: hilo_muldiv_ctrl
// PURPOSE
//  Sequences every HI/LO update in the dynamic pipeline: MULT/MULTU/DIV/DIVU run as multi-cycle ops, MTHI/MTLO as direct writes.
//  Drives the HI/LO pair's write inputs every cycle, since that pair latches unconditionally on negedge clk.
//  Sits beside EX; stalls ID/EX while busy so MFHI/MFLO and new HI/LO ops never see stale or torn values.
// PARAMETERS
//  WIDTH   32  operand/HI/LO width; only 32 is verified
//  CNT_W   6   iteration counter width; must hold WIDTH
// PORTS
//  clk       in   1      pipeline clock; state updates on posedge
//  rst       in   1      reset, synchronous, active-high
//  op_valid  in   1      EX presents an HI/LO op this cycle
//  op        in   3      op code, muldiv_pkg: NOP=0 MULT=1 MULTU=2 DIV=3 DIVU=4 MTHI=5 MTLO=6
//  rs_val    in   WIDTH  rs operand (dividend/multiplicand/MT source)
//  rt_val    in   WIDTH  rt operand (divisor/multiplier)
//  mf_req    in   1      MFHI/MFLO in EX this cycle
//  hi_rd     in   WIDTH  current HI, from the HI/LO pair
//  lo_rd     in   WIDTH  current LO
//  op_ready  out  1      op accepted this cycle (op_valid & op_ready)
//  stall     out  1      freeze ID/EX: busy & (op_valid | mf_req)
//  busy      out  1      multi-cycle op in flight
//  hi_wdata  out  WIDTH  value HI latches at the next negedge
//  lo_wdata  out  WIDTH  value LO latches at the next negedge
//  done      out  1      one-cycle pulse in the WB cycle
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, counter=0; op_ready=1. hi_wdata/lo_wdata pass hi_rd/lo_rd through.
//  Hold rule: outside WB and MT writes, hi_wdata=hi_rd and lo_wdata=lo_rd, so HI/LO keep their value.
//  FSM: IDLE -> MUL|DIV (accept) -> FIX -> WB -> IDLE.
//  IDLE: op_ready=1. MTHI: hi_wdata=rs_val the same cycle, no state change; MTLO likewise on lo_wdata.
//    MULT(U)/DIV(U): latch |operands| plus sign flags (signed ops only), counter=0, go MUL/DIV.
//  MUL/DIV: busy=1, op_ready=0. One shift-add or restoring-subtract step per cycle for 32 cycles (counter 0..31).
//  FIX: apply signs. Product negated if signs differ. Quotient negated if signs differ. Remainder takes dividend sign.
//  WB: hi_wdata=HI result, lo_wdata=LO result, done=1, busy=1; next cycle IDLE.
//  Latency: accept edge to WB cycle = 34 cycles; a new op is accepted in the cycle after WB.
//  Results: MULT(U): {HI,LO} = 64-bit product. DIV(U): LO=quotient, HI=remainder.
//  Divide by zero (both DIV and DIVU): LO=32'hFFFF_FFFF, HI=rs_val. Iteration still runs; latency unchanged.
//  Signed overflow 0x8000_0000 / -1: LO=0x8000_0000, HI=0.
//  op_valid while busy: op_ready=0, op ignored; requester holds it under stall. Applies to MTHI/MTLO too.
//  mf_req while busy: stall=1 through WB. In IDLE, mf_req never stalls.
//  op=NOP or op>6 with op_valid: accepted, no effect.
//  rst mid-op: abort next edge to IDLE. No WB, done=0, outputs return to pass-through.
// CONFIGURATION
//  MULDIV_FAST_MUL_EN defined: MULT(U) uses a registered single-cycle signed/unsigned multiply.
//    Path is MUL(1 cycle) -> WB, skipping FIX; accept to WB = 2 cycles. DIV(U) is unchanged.
//  Not defined: iterative 32-cycle multiply as above (34 cycles), no hardware multiplier inferred.
// STRUCTURE
//  muldiv_pkg holds op codes, state enum {IDLE,MUL,DIV,FIX,WB}, and the divide-by-zero/overflow constants.
//  Sub-module div_iter is the unsigned restoring-divide datapath: one step per enable, with quotient/remainder regs.
//  Sign handling, FSM, multiply and the hold mux stay in this module.
// TESTING
//  1. MULT rs=0xFFFF_FFFE rt=3: busy 34 cycles; WB gives HI=0xFFFF_FFFF, LO=0xFFFF_FFFA; done pulses once.
//  2. DIVU 100/7 gives LO=14, HI=2. DIV -7/2 gives LO=0xFFFF_FFFD, HI=0xFFFF_FFFF.
//  3. DIV 5/0 gives LO=0xFFFF_FFFF, HI=5. DIV 0x8000_0000/0xFFFF_FFFF gives LO=0x8000_0000, HI=0.
//  4. MTHI 0x1234 issued at iteration 5 of a DIVU: op_ready=0 and stall=1 until IDLE; HI=0x1234 the cycle after WB.
//     mf_req during busy keeps stall=1.
//  5. rst at iteration 10 of MULTU: busy=0 next cycle, done never pulses, hi_wdata==hi_rd.
//  6. MULTU 0xFFFF_FFFF^2 gives HI=0xFFFF_FFFE, LO=1. Run with MULDIV_FAST_MUL_EN (WB 2 cycles after accept) and without (34).

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state encodings and special-case divide results
// for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MUL  = 3'd1;
  localparam logic [2:0] ST_DIV  = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_WB   = 3'd4;

  localparam logic [31:0] DIV0_LO      = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_DIVIDEND = 32'h8000_0000;
  localparam logic [31:0] OVF_DIVISOR  = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_LO       = 32'h8000_0000;
  localparam logic [31:0] OVF_HI       = 32'h0000_0000;

endpackage

// File: rtl/div_iter.sv
// Unsigned restoring divider: load captures operands, each enable retires
// one quotient bit; after WIDTH enables quot/rem hold the result.
module div_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  logic [WIDTH-1:0] dsr;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  always_comb begin
    shifted = {rem, quot[WIDTH-1]};
    diff    = shifted - {1'b0, dsr};
  end

  // quot doubles as the dividend shift register; its low bits fill with result bits
  always_ff @(posedge clk) begin
    if (rst) begin
      quot <= '0;
      rem  <= '0;
      dsr  <= '0;
    end else if (load) begin
      quot <= dividend;
      rem  <= '0;
      dsr  <= divisor;
    end else if (en) begin
      if (!diff[WIDTH]) begin
        rem  <= diff[WIDTH-1:0];
        quot <= {quot[WIDTH-2:0], 1'b1};
      end else begin
        rem  <= shifted[WIDTH-1:0];
        quot <= {quot[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO update sequencer: multi-cycle MULT(U)/DIV(U), direct MTHI/MTLO, hold mux.
// Define MULDIV_FAST_MUL_EN for a registered single-cycle multiply path.
module hilo_muldiv_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mf_req,
  input  logic [WIDTH-1:0] hi_rd,
  input  logic [WIDTH-1:0] lo_rd,
  output logic             op_ready,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] hi_wdata,
  output logic [WIDTH-1:0] lo_wdata,
  output logic             done
);
  import muldiv_pkg::*;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [2:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   prod_hi, prod_lo;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic               neg_q, neg_r, div_op, div0, ovf;
  logic               is_mul, is_div, is_signed, accept;
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH-1:0]   quot, rem;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;

  always_comb begin
    is_mul    = 1'b0;
    is_div    = 1'b0;
    is_signed = 1'b0;
    case (op)
      OP_NOP:   ;
      OP_MULT:  begin is_mul = 1'b1; is_signed = 1'b1; end
      OP_MULTU: is_mul = 1'b1;
      OP_DIV:   begin is_div = 1'b1; is_signed = 1'b1; end
      OP_DIVU:  is_div = 1'b1;
      default:  ;
    endcase
  end

  assign op_ready = (state == ST_IDLE);
  assign accept   = op_valid & op_ready;
  assign busy     = (state != ST_IDLE);
  assign stall    = busy & (op_valid | mf_req);
  assign done     = (state == ST_WB);

  assign sign_a = is_signed & rs_val[WIDTH-1];
  assign sign_b = is_signed & rt_val[WIDTH-1];
  assign abs_a  = sign_a ? -rs_val : rs_val;
  assign abs_b  = sign_b ? -rt_val : rt_val;

  div_iter #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (accept & is_div),
    .en       (state == ST_DIV),
    .dividend (abs_a),
    .divisor  (abs_b),
    .quot     (quot),
    .rem      (rem)
  );

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] mag, fast_prod;
  always_comb begin
    mag       = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, prod_lo};
    fast_prod = neg_q ? -mag : mag;
  end
`else
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, prod_hi} + (prod_lo[0] ? {1'b0, op_a} : '0);
`endif

  // Divide-by-zero keeps |rs| as remainder, so the dividend-sign fix restores rs exactly
  always_comb begin
    prod_s = {prod_hi, prod_lo};
    if (neg_q) prod_s = -prod_s;
    quo_s = neg_q ? -quot : quot;
    rem_s = neg_r ? -rem : rem;
    if (div0) quo_s = DIV0_LO;
    if (ovf) begin
      quo_s = OVF_LO;
      rem_s = OVF_HI;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      op_a    <= '0;
      prod_hi <= '0;
      prod_lo <= '0;
      res_hi  <= '0;
      res_lo  <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      div_op  <= 1'b0;
      div0    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (accept && (is_mul || is_div)) begin
          op_a    <= abs_a;
          prod_hi <= '0;
          prod_lo <= abs_b;
          neg_q   <= sign_a ^ sign_b;
          neg_r   <= sign_a;
          div_op  <= is_div;
          div0    <= is_div && (rt_val == '0);
          ovf     <= is_div && is_signed && (rs_val == OVF_DIVIDEND) && (rt_val == OVF_DIVISOR);
          cnt     <= '0;
          state   <= is_mul ? ST_MUL : ST_DIV;
        end
        ST_MUL: begin
`ifdef MULDIV_FAST_MUL_EN
          {res_hi, res_lo} <= fast_prod;
          state <= ST_WB;
`else
          {prod_hi, prod_lo} <= {mul_sum, prod_lo[WIDTH-1:1]};
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) state <= ST_FIX;
`endif
        end
        ST_DIV: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) state <= ST_FIX;
        end
        ST_FIX: begin
          res_hi <= div_op ? rem_s : prod_s[2*WIDTH-1:WIDTH];
          res_lo <= div_op ? quo_s : prod_s[WIDTH-1:0];
          state  <= ST_WB;
        end
        ST_WB:   state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    hi_wdata = hi_rd;
    lo_wdata = lo_rd;
    if (state == ST_WB) begin
      hi_wdata = res_hi;
      lo_wdata = res_lo;
    end else if (accept && !rst) begin
      if (op == OP_MTHI) hi_wdata = rs_val;
      if (op == OP_MTLO) lo_wdata = rs_val;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench for hilo_muldiv_ctrl with a negedge-latching HI/LO model.
module tb_hilo_muldiv_ctrl;

  localparam logic [2:0] T_NOP = 3'd0, T_MULT = 3'd1, T_MULTU = 3'd2, T_DIV = 3'd3;
  localparam logic [2:0] T_DIVU = 3'd4, T_MTHI = 3'd5, T_MTLO = 3'd6;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT  = 2;
  localparam int ABORT_AT = 0;
`else
  localparam int MUL_LAT  = 34;
  localparam int ABORT_AT = 10;
`endif
  localparam int DIV_LAT = 34;

  logic        clk = 1'b0, rst = 1'b1, op_valid = 1'b0, mf_req = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] rs_val = '0, rt_val = '0;
  logic [31:0] hi_q = 32'h1111_1111, lo_q = 32'h2222_2222;
  logic        op_ready, stall, busy, done;
  logic [31:0] hi_wdata, lo_wdata;

  int tests = 0, fails = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  always @(negedge clk) begin
    hi_q <= hi_wdata;
    lo_q <= lo_wdata;
  end

  hilo_muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .mf_req(mf_req), .hi_rd(hi_q), .lo_rd(lo_q), .op_ready(op_ready), .stall(stall),
    .busy(busy), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata), .done(done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv, q, r;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    case (o)
      T_MULT:  return 64'(sa * sbv);
      T_MULTU: return {32'b0, a} * {32'b0, b};
      T_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sbv;
        r = sa % sbv;
        return {r[31:0], q[31:0]};
      end
      T_DIVU:  return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: return 64'h0;
    endcase
  endfunction

  task automatic pop_compare(input string tag);
    logic [63:0] e;
    check({tag, ":sb_pending"}, 64'(exp_q.size()), 64'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, ":wb_data"}, {hi_wdata, lo_wdata}, e);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int lat_exp);
    int lat, nbusy;
    bit seen;
    @(posedge clk); #1;
    op_valid = 1'b1; op = o; rs_val = a; rt_val = b;
    exp_q.push_back(exp);
    @(negedge clk);
    check({tag, ":ready"}, 64'(op_ready), 64'd1);
    @(posedge clk); #1;
    op_valid = 1'b0; rs_val = '0; rt_val = '0;
    lat = 0; nbusy = 0; seen = 0;
    while (!seen && lat < 80) begin
      @(negedge clk);
      lat++;
      if (busy) nbusy++;
      if (done) begin
        seen = 1;
        pop_compare(tag);
      end
    end
    check({tag, ":done_seen"}, 64'(seen), 64'd1);
    check({tag, ":latency"}, 64'(lat), 64'(lat_exp));
    check({tag, ":busy_cycles"}, 64'(nbusy), 64'(lat_exp));
    @(negedge clk);
    check({tag, ":post_done_busy"}, {62'b0, done, busy}, 64'd0);
    check({tag, ":hilo_latched"}, {hi_q, lo_q}, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n, ndone;
    bit seen;
    logic [2:0] ro;
    logic [31:0] ra, rb;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ready", 64'(op_ready), 64'd1);
    check("rst_passthru", {hi_wdata, lo_wdata}, {32'h1111_1111, 32'h2222_2222});

    @(posedge clk); #1 mf_req = 1'b1;
    @(negedge clk);
    check("idle_mf_no_stall", 64'(stall), 64'd0);

    @(posedge clk); #1 mf_req = 1'b0; op_valid = 1'b1; op = T_MTLO; rs_val = 32'hCAFE_F00D;
    @(negedge clk);
    check("mtlo_same_cycle", {hi_wdata, lo_wdata}, {32'h1111_1111, 32'hCAFE_F00D});
    @(posedge clk); #1 op = T_MTHI; rs_val = 32'h600D_BEEF;
    @(negedge clk);
    check("mthi_same_cycle", {hi_wdata, lo_wdata}, {32'h600D_BEEF, 32'hCAFE_F00D});
    @(posedge clk); #1 op = 3'd7; rs_val = 32'hDEAD_DEAD;
    @(negedge clk);
    check("op7_ready", 64'(op_ready), 64'd1);
    check("op7_no_effect", {hi_wdata, lo_wdata}, {32'h600D_BEEF, 32'hCAFE_F00D});
    @(posedge clk); #1 op = T_NOP;
    @(negedge clk);
    check("nop_no_effect", {hi_wdata, lo_wdata}, {32'h600D_BEEF, 32'hCAFE_F00D});
    check("nop_idle", 64'(busy), 64'd0);
    @(posedge clk); #1 op_valid = 1'b0;

    run_op("mult_neg", T_MULT, 32'hFFFF_FFFE, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFFA}, MUL_LAT);
    run_op("divu_100_7", T_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, DIV_LAT);
    run_op("div_m7_2", T_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, DIV_LAT);
    run_op("div_5_0", T_DIV, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, DIV_LAT);
    run_op("div_m5_0", T_DIV, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, DIV_LAT);
    run_op("div_ovf", T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, DIV_LAT);
    run_op("multu_max", T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h1}, MUL_LAT);

    for (int i = 0; i < 6; i++) begin
      ro = 3'(1 + (i % 4));
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      run_op("random", ro, ra, rb, model(ro, ra, rb), (ro <= T_MULTU) ? MUL_LAT : DIV_LAT);
    end

    // MTHI and mf_req held against an in-flight DIVU
    @(posedge clk); #1 op_valid = 1'b1; op = T_DIVU; rs_val = 32'd1000; rt_val = 32'd9;
    exp_q.push_back({32'd1, 32'd111});
    @(posedge clk); #1 op_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 op_valid = 1'b1; op = T_MTHI; rs_val = 32'h0000_1234; mf_req = 1'b1;
    n = 0; seen = 0;
    while (!seen && n < 80) begin
      @(negedge clk);
      n++;
      check("mthi_busy_ready", 64'(op_ready), 64'd0);
      check("mthi_busy_stall", 64'(stall), 64'd1);
      if (done) begin
        seen = 1;
        pop_compare("divu_under_mthi");
      end
    end
    check("divu_under_mthi:done_seen", 64'(seen), 64'd1);
    @(negedge clk);
    check("mthi_after_wb_ready", 64'(op_ready), 64'd1);
    check("mthi_after_wb_stall", 64'(stall), 64'd0);
    check("mthi_after_wb_data", {hi_wdata, lo_wdata}, {32'h0000_1234, 32'd111});
    @(posedge clk); #1 op_valid = 1'b0; mf_req = 1'b0;
    @(negedge clk);
    check("mthi_latched", 64'(hi_q), 64'h1234);

    // reset abort in the middle of a MULTU
    @(posedge clk); #1 op_valid = 1'b1; op = T_MULTU; rs_val = 32'h1234_5678; rt_val = 32'h9ABC_DEF0;
    @(posedge clk); #1 op_valid = 1'b0;
    repeat (ABORT_AT) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_passthru", {hi_wdata, lo_wdata}, {hi_q, lo_q});
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", 64'(ndone), 64'd0);
    check("abort_hilo_kept", {hi_q, lo_q}, {32'h0000_1234, 32'd111});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
